systolic_feed_ctrl: RTL and testbench

SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

---
 rtl/systolic_feed_ctrl.sv | 117 +++++++++++
 tb/tb_systolic_feed_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_ctrl.sv
// 3x3 systolic array feed sequencer: latches A/B, skews them onto the
// west/north edges, then drains, captures and reports done.
module systolic_feed_ctrl #(
  parameter int DATA_W  = 8,
  parameter int MAC_LAT = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [9*DATA_W-1:0] a_mat_i,
  input  logic [9*DATA_W-1:0] b_mat_i,
  output logic [DATA_W-1:0]   a_row0_o,
  output logic [DATA_W-1:0]   a_row1_o,
  output logic [DATA_W-1:0]   a_row2_o,
  output logic [DATA_W-1:0]   b_col0_o,
  output logic [DATA_W-1:0]   b_col1_o,
  output logic [DATA_W-1:0]   b_col2_o,
  output logic                pe_clear_o,
  output logic                pe_en_o,
  output logic                capture_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_CAPTURE,
    S_DONE
  } state_e;

  localparam logic [2:0] FEED_LAST  = 3'd4;
  localparam logic [2:0] DRAIN_LAST = 3'(1 + MAC_LAT);

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [9*DATA_W-1:0]  a_q, b_q;
  logic                 lat_en;
  logic                 run;
  logic [2:0][DATA_W-1:0] a_feed, b_feed;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (lat_en) begin
        a_q <= a_mat_i;
        b_q <= b_mat_i;
      end
    end
  end

  assign run = (state_q == S_CLEAR) || (state_q == S_FEED) ||
               (state_q == S_DRAIN) || (state_q == S_CAPTURE);

  always_comb begin
    state_d = state_q;
    lat_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = S_CLEAR;
          lat_en  = 1'b1;
        end
      end
      S_CLEAR:   state_d = S_FEED;
      S_FEED:    if (cnt_q == FEED_LAST) state_d = S_DRAIN;
      S_DRAIN:   if (cnt_q == DRAIN_LAST) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_DONE;
      S_DONE:    if (!start_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    // abort only cancels an active run; IDLE/DONE ignore it
    if (run && abort_i) state_d = S_IDLE;
  end

  always_comb begin
    cnt_d = cnt_q + 3'd1;
    if (state_d != state_q || !run) cnt_d = '0;
  end

  always_comb begin
    a_feed = '0;
    b_feed = '0;
    if (state_q == S_FEED) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 3; k++) begin
          if (int'(cnt_q) == i + k) begin
            a_feed[i] = a_q[DATA_W*(3*i+k) +: DATA_W];
            b_feed[i] = b_q[DATA_W*(3*k+i) +: DATA_W];
          end
        end
      end
    end
  end

  assign a_row0_o   = a_feed[0];
  assign a_row1_o   = a_feed[1];
  assign a_row2_o   = a_feed[2];
  assign b_col0_o   = b_feed[0];
  assign b_col1_o   = b_feed[1];
  assign b_col2_o   = b_feed[2];
  assign pe_clear_o = (state_q == S_CLEAR);
  assign pe_en_o    = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign capture_o  = (state_q == S_CAPTURE);
  assign busy_o     = run;
  assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl: feed skew, latency, abort,
// reset and handshake, plus a MAC_LAT=3 instance.
module tb_systolic_feed_ctrl;

  logic clk = 1'b0;
  logic rst, start, abort, start3;
  logic [71:0] a_mat, b_mat;
  logic [7:0] a0, a1, a2, b0, b1, b2;
  logic clr, pen, cap, busy, done;
  logic [7:0] x_a0, x_a1, x_a2, x_b0, x_b1, x_b2;
  logic x_clr, x_pen, x_cap, x_busy, x_done;

  int vecs = 0;
  int errs = 0;
  int pe_n = 0;
  int pe3_n = 0;
  int cap_e, done_e;
  logic seen;

  always #5 clk = ~clk;

  systolic_feed_ctrl #(.DATA_W(8), .MAC_LAT(1)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .abort_i(abort),
    .a_mat_i(a_mat), .b_mat_i(b_mat),
    .a_row0_o(a0), .a_row1_o(a1), .a_row2_o(a2),
    .b_col0_o(b0), .b_col1_o(b1), .b_col2_o(b2),
    .pe_clear_o(clr), .pe_en_o(pen), .capture_o(cap),
    .busy_o(busy), .done_o(done)
  );

  systolic_feed_ctrl #(.DATA_W(8), .MAC_LAT(3)) dut3 (
    .clk_i(clk), .reset_i(rst), .start_i(start3), .abort_i(abort),
    .a_mat_i(a_mat), .b_mat_i(b_mat),
    .a_row0_o(x_a0), .a_row1_o(x_a1), .a_row2_o(x_a2),
    .b_col0_o(x_b0), .b_col1_o(x_b1), .b_col2_o(x_b2),
    .pe_clear_o(x_clr), .pe_en_o(x_pen), .capture_o(x_cap),
    .busy_o(x_busy), .done_o(x_done)
  );

  wire [52:0] outs = {a0, a1, a2, b0, b1, b2, clr, pen, cap, busy, done};
  wire [23:0] arow = {a0, a1, a2};
  wire [23:0] bcol = {b0, b1, b2};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pen) pe_n++;
    if (x_pen) pe3_n++;
  endtask

  // A = {0,1,1;1,0,1;1,1,0}, B = {1,-.5,1;-1.5,2,-1.5;1,-.5,1}
  localparam logic [71:0] A_MAT = {8'h00, 8'h30, 8'h30,
                                   8'h30, 8'h00, 8'h30,
                                   8'h30, 8'h30, 8'h00};
  localparam logic [71:0] B_MAT = {8'h30, 8'hA0, 8'h30,
                                   8'hB8, 8'h40, 8'hB8,
                                   8'h30, 8'hA0, 8'h30};

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; start3 = 1'b0;
    a_mat = A_MAT; b_mat = B_MAT;
    step();
    chk("reset_outs", 64'(outs), 64'd0);
    start = 1'b1;
    step();
    chk("reset_over_start", 64'(outs), 64'd0);

    rst = 1'b0; abort = 1'b1;
    step();
    chk("abort_wins_idle", 64'(outs), 64'd0);

    abort = 1'b0; pe_n = 0;
    step();
    chk("clear", 64'({clr, pen, busy, done}), 64'b1010);
    chk("clear_feeds", 64'({arow, bcol}), 64'd0);
    step();
    chk("t0_a", 64'(arow), 64'h00_00_00);
    chk("t0_b", 64'(bcol), 64'h30_00_00);
    chk("t0_en", 64'({clr, pen}), 64'b01);
    step();
    chk("t1_a", 64'(arow), 64'h30_30_00);
    chk("t1_b", 64'(bcol), 64'hB8_A0_00);
    start = 1'b0;
    step();
    chk("t2_a", 64'(arow), 64'h30_00_30);
    chk("t2_b", 64'(bcol), 64'h30_40_30);
    start = 1'b1;
    a_mat = {9{8'h40}};
    step();
    chk("t3_a_latched", 64'(arow), 64'h00_30_30);
    chk("t3_b", 64'(bcol), 64'h00_A0_B8);
    step();
    chk("t4_a", 64'(arow), 64'h00_00_00);
    chk("t4_b", 64'(bcol), 64'h00_00_30);
    chk("t4_busy", 64'({pen, busy}), 64'b11);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("drain", 64'({pen, cap, busy, arow, bcol}), {61'd0, 3'b101} << 48);
    end
    step();
    chk("capture_e10", 64'({pen, cap, busy, done}), 64'b0110);
    step();
    chk("done_e11", 64'({cap, busy, done}), 64'b001);
    chk("pe_en_run1", 64'(pe_n), 64'd8);
    abort = 1'b1;
    step();
    step();
    chk("done_held", 64'({busy, done}), 64'b01);
    abort = 1'b0; start = 1'b0;
    step();
    chk("done_to_idle", 64'(outs), 64'd0);

    a_mat = A_MAT;
    start = 1'b1; pe_n = 0; cap_e = 0; done_e = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (cap && cap_e == 0) cap_e = n;
      if (done && done_e == 0) done_e = n;
    end
    chk("run2_cap_edge", 64'(cap_e), 64'd10);
    chk("run2_done_edge", 64'(done_e), 64'd11);
    chk("run2_pe_en", 64'(pe_n), 64'd8);
    start = 1'b0;
    step();

    start = 1'b1;
    repeat (7) step();
    chk("abort_pre_drain", 64'({pen, cap, busy}), 64'b101);
    abort = 1'b1;
    step();
    chk("abort_drain_idle", 64'(outs), 64'd0);
    abort = 1'b0; start = 1'b0; seen = 1'b0;
    repeat (4) begin
      step();
      seen = seen | cap | done;
    end
    chk("abort_no_cap_done", 64'(seen), 64'd0);

    start = 1'b1;
    repeat (5) step();
    chk("rst_pre_t3", 64'(arow), 64'h00_30_30);
    rst = 1'b1;
    step();
    chk("rst_mid_feed", 64'(outs), 64'd0);
    rst = 1'b0;
    step();
    chk("restart_after_rst", 64'({clr, busy}), 64'b11);
    start = 1'b0;
    repeat (12) step();
    chk("rst_run_end_idle", 64'(outs), 64'd0);

    start3 = 1'b1; pe3_n = 0; cap_e = 0; done_e = 0;
    for (int n = 1; n <= 15; n++) begin
      step();
      if (x_cap && cap_e == 0) cap_e = n;
      if (x_done && done_e == 0) done_e = n;
    end
    chk("ml3_cap_edge", 64'(cap_e), 64'd12);
    chk("ml3_done_edge", 64'(done_e), 64'd13);
    chk("ml3_pe_en", 64'(pe3_n), 64'd10);
    chk("ml3_dut1_idle", 64'(outs), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
